demux_scheduler: RTL and testbench

DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

---
 rtl/demux_scheduler.sv | 117 +++++++++++
 tb/tb_demux_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_scheduler.sv
// Single-entry buffered 1-to-4 demux scheduler: each buffered word is steered to one
// channel chosen by burst-limited round-robin over enabled channels, or by a fixed select.
module demux_scheduler #(
    parameter int WIDTH = 8,
    parameter int BURST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       fixed_sel,
    input  logic [3:0]       en_mask,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    output logic [1:0]       sel,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEEK = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

    logic [1:0]       state;
    logic             buf_full;
    logic [WIDTH-1:0] buf_data;
    logic [1:0]       sel_q;
    logic [7:0]       burst_cnt;

    logic chan_ok;
    logic fire;
    logic accept;
    logic burst_done;

    // First enabled channel after cur (cur+1, cur+2, cur+3); falls back to cur itself.
    function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] pick;
        pick = cur;
        for (int k = 3; k >= 1; k--) begin
            if (mask[cur + 2'(k)]) pick = cur + 2'(k);
        end
        return pick;
    endfunction

    always_comb begin
        chan_ok    = en_mask[sel_q] & (~mode | (sel_q == fixed_sel));
        fire       = buf_full & out_ready[sel_q];
        in_ready   = chan_ok & (~buf_full | fire);
        accept     = in_valid & in_ready;
        burst_done = (burst_cnt == BURST_LAST);
    end

    assign out_data  = buf_data;
    assign out_valid = buf_full ? (4'b0001 << sel_q) : 4'b0000;
    assign sel       = sel_q;
    assign busy      = buf_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full  <= 1'b0;
            buf_data  <= '0;
            sel_q     <= 2'd0;
            burst_cnt <= 8'd0;
            state     <= (en_mask[0] & (~mode | (fixed_sel == 2'd0))) ? IDLE : SEEK;
        end else begin
            if (accept) buf_data <= data;
            buf_full <= accept | (buf_full & ~fire);

            case (state)
                IDLE: begin
                    if (mode) burst_cnt <= 8'd0;
                    if (accept)        state <= FULL;
                    else if (!chan_ok) state <= SEEK;
                end
                SEEK: begin
                    if (accept) begin
                        state <= FULL;
                    end else if (chan_ok) begin
                        burst_cnt <= 8'd0;
                        state     <= IDLE;
                    end else if (!mode) begin
                        // An all-zero mask parks here with sel untouched.
                        if (en_mask != 4'b0000) begin
                            sel_q     <= next_enabled(sel_q, en_mask);
                            burst_cnt <= 8'd0;
                            state     <= IDLE;
                        end
                    end else begin
                        sel_q     <= fixed_sel;
                        burst_cnt <= 8'd0;
                        state     <= en_mask[fixed_sel] ? IDLE : SEEK;
                    end
                end
                FULL: begin
                    // sel only moves on a fire, so the held word never changes channel.
                    if (fire) begin
                        if (mode) begin
                            burst_cnt <= 8'd0;
                        end else if (burst_done) begin
                            burst_cnt <= 8'd0;
                            sel_q     <= next_enabled(sel_q, en_mask);
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                        state <= accept ? FULL : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_scheduler.sv
// Randomized and directed bench for demux_scheduler with a queue scoreboard and a
// word-sequence reference model of the channel schedule.
module tb_demux_scheduler;

    localparam int WIDTH = 8;
    localparam int BURST = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [1:0]       fixed_sel;
    logic [3:0]       en_mask;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_valid;
    logic [1:0]       sel;
    logic             busy;

    always #5 clk = ~clk;

    demux_scheduler #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .data(data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .fixed_sel(fixed_sel), .en_mask(en_mask), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .sel(sel), .busy(busy)
    );

    typedef struct packed {
        logic [1:0]       chan;
        logic [WIDTH-1:0] d;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t e;
    logic [1:0] m_sel = 2'd0;
    int   m_cnt = 0;
    int   seen[4];
    bit   rand_or = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: nearest enabled channel after s, else s itself.
    function automatic logic [1:0] model_next(input logic [1:0] s, input logic [3:0] m);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (int'(s) + k) % 4;
            if (m[idx]) return 2'(idx);
        end
        return s;
    endfunction

    function automatic bit model_ok(input logic [1:0] s);
        return en_mask[s] && (mode == 1'b0 || s == fixed_sel);
    endfunction

    // Scoreboard: fires pop and compare first, then accepts push the next expectation.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_sel = 2'd0;
            m_cnt = 0;
        end else begin
            check("busy_vs_valid", 32'(busy), 32'(out_valid != 4'b0000));
            if (out_valid != 4'b0000)
                check("valid_has_word", 32'(sb_q.size() > 0), 32'd1);
            if ((out_valid & out_ready) != 4'b0000 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("fire_chan", 32'(out_valid), 32'(4'b0001 << e.chan));
                check("fire_data", 32'(out_data), 32'(e.d));
                seen[e.chan]++;
                if (mode == 1'b0) begin
                    m_cnt++;
                    if (m_cnt == BURST) begin
                        m_cnt = 0;
                        m_sel = model_next(m_sel, en_mask);
                    end
                end else begin
                    m_cnt = 0;
                end
            end
            if (in_valid && in_ready) begin
                if (!busy && !model_ok(m_sel)) begin
                    m_sel = mode ? fixed_sel : model_next(m_sel, en_mask);
                    m_cnt = 0;
                end
                e.chan = m_sel;
                e.d    = data;
                sb_q.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_or) out_ready = 4'($urandom);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        data     = d;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = in_ready;
            if (!got) waits++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0h not accepted within 200 cycles", d);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty    = 1'b0;
        in_valid = 1'b0;
        rand_or  = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 4'hF;
        for (int n = 0; n < 200 && !empty; n++) begin
            @(negedge clk);
            empty = !busy;
        end
        if (!empty) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: busy still %0b after 200 cycles", busy);
        end
        tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) seen[i] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wsum;
        rst = 1'b1; in_valid = 1'b0; data = '0; mode = 1'b0; fixed_sel = 2'd0;
        en_mask = 4'hF; out_ready = 4'hF;
        clear_seen();
        apply_reset();

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        tick();

        // Full-rate round robin over all four channels.
        clear_seen();
        wsum = 0;
        for (int i = 1; i <= 8; i++) begin
            send_word(8'(i), w);
            wsum += w;
        end
        drain();
        check("rr_stall_cycles", 32'(wsum), 32'd0);
        for (int c = 0; c < 4; c++) check("rr_per_chan", 32'(seen[c]), 32'd2);

        // Sparse mask skips disabled channels.
        apply_reset();
        en_mask = 4'b0101;
        tick();
        clear_seen();
        for (int i = 0; i < 6; i++) send_word(8'(8'h10 + i), w);
        drain();
        check("mask_ch0", 32'(seen[0]), 32'd4);
        check("mask_ch1", 32'(seen[1]), 32'd0);
        check("mask_ch2", 32'(seen[2]), 32'd2);
        check("mask_ch3", 32'(seen[3]), 32'd0);

        // Back-pressure on channel 1 holds the word in place.
        apply_reset();
        en_mask = 4'hF;
        send_word(8'h01, w);
        send_word(8'h02, w);
        drain();
        out_ready = 4'b0000;
        send_word(8'hA5, w);
        in_valid = 1'b1;
        data     = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'b0010);
            check("hold_in_ready", 32'(in_ready), 32'h0);
            check("hold_sel", 32'(sel), 32'h1);
            check("hold_out_data", 32'(out_data), 32'hA5);
        end
        tick();
        out_ready = 4'b0010;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        drain();

        // Fixed mode waits for its channel to be enabled.
        mode      = 1'b1;
        fixed_sel = 2'd3;
        en_mask   = 4'b0111;
        tick(); tick(); tick();
        @(negedge clk);
        check("fixed_blocked_in_ready", 32'(in_ready), 32'h0);
        check("fixed_blocked_busy", 32'(busy), 32'h0);
        tick();
        en_mask = 4'hF;
        tick();
        @(negedge clk);
        check("fixed_open_in_ready", 32'(in_ready), 32'h1);
        check("fixed_open_sel", 32'(sel), 32'h3);
        tick();
        clear_seen();
        for (int i = 0; i < 4; i++) send_word(8'(8'h30 + i), w);
        drain();
        check("fixed_ch3", 32'(seen[3]), 32'd4);
        check("fixed_others", 32'(seen[0] + seen[1] + seen[2]), 32'd0);
        mode = 1'b0;

        // Reset while holding a word discards it.
        out_ready = 4'b0000;
        send_word(8'hEE, w);
        tick();
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_sel", 32'(sel), 32'h0);
        check("midrst_out_data", 32'(out_data), 32'h0);
        tick();
        out_ready = 4'hF;
        repeat (5) tick();

        // Mask cleared while full on channel 2: word still goes out on channel 2.
        for (int i = 0; i < 4; i++) send_word(8'(8'h40 + i), w);
        drain();
        out_ready = 4'b0000;
        send_word(8'h77, w);
        en_mask = 4'b0000;
        tick(); tick();
        drain();
        in_valid = 1'b1;
        data     = 8'h88;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nomask_sel", 32'(sel), 32'h2);
            check("nomask_in_ready", 32'(in_ready), 32'h0);
        end
        tick();
        in_valid = 1'b0;
        en_mask  = 4'b0001;
        tick(); tick();
        @(negedge clk);
        check("remask_sel", 32'(sel), 32'h0);
        check("remask_in_ready", 32'(in_ready), 32'h1);
        tick();
        send_word(8'h99, w);
        drain();

        // Randomized configurations, gaps and back-pressure.
        for (int r = 0; r < 6; r++) begin
            drain();
            mode      = 1'($urandom);
            fixed_sel = 2'($urandom);
            en_mask   = 4'($urandom_range(1, 15));
            if (mode) en_mask[fixed_sel] = 1'b1;
            tick(); tick(); tick();
            rand_or = 1'b1;
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_word(8'($urandom), w);
            end
            drain();
        end

        check("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
